vsa_mem_responder: RTL

//  Memory-side responder for the 12-bit Very Simple Architecture CPU (5-bit PC/data).

---
 rtl/vsa_mem_responder_if.sv | 33 +++
 rtl/vsa_mem_responder.sv | 58 +++++
 2 files changed

// File: rtl/vsa_mem_responder_if.sv
// vsa_mem_responder_if: CPU fetch/data bus and loader bus between the VSA core side and the memory responder
interface vsa_mem_responder_if #(
    parameter int IW = 12,
    parameter int DW = 5,
    parameter int AW = 5,
    parameter int CW = 8
);
    logic [AW-1:0] pc;
    logic [IW-1:0] instruction;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
    logic [DW-1:0] datain;
    logic          ld_start;
    logic          ld_valid;
    logic          ld_ready;
    logic          ld_sel;
    logic [AW-1:0] ld_addr;
    logic [IW-1:0] ld_data;
    logic          ld_last;
    logic          loading;
    logic [CW-1:0] wr_count;

    modport master (
        output pc, addr, wdata, wr, ld_start, ld_valid, ld_sel, ld_addr, ld_data, ld_last,
        input  instruction, datain, ld_ready, loading, wr_count
    );

    modport slave (
        input  pc, addr, wdata, wr, ld_start, ld_valid, ld_sel, ld_addr, ld_data, ld_last,
        output instruction, datain, ld_ready, loading, wr_count
    );
endinterface

// File: rtl/vsa_mem_responder.sv
// vsa_mem_responder: instruction/data memories for the VSA CPU with a loader port that stalls fetch with bubbles
module vsa_mem_responder #(
    parameter int          IW     = 12,
    parameter int          DW     = 5,
    parameter int          AW     = 5,
    parameter int          CW     = 8,
    parameter logic [11:0] BUBBLE = 12'hC00
) (
    input logic clock,
    input logic reset,
    vsa_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {RUN, LOAD, FLUSH} state_t;

    state_t        state, state_next;
    logic [IW-1:0] imem [2**AW];
    logic [DW-1:0] dmem [2**AW];
    logic          accept;

    // a CPU store owns the single dmem write port, so the loader is held off
    assign bus.ld_ready = (state == LOAD) & ~(bus.ld_sel & bus.wr);
    assign accept       = bus.ld_valid & bus.ld_ready;
    assign bus.loading  = state != RUN;
    assign bus.datain   = dmem[bus.addr];

    always_comb begin
        state_next = state;
        if (state == RUN)
            state_next = bus.ld_start ? LOAD : RUN;
        else if (state == LOAD)
            state_next = (accept & bus.ld_last) ? FLUSH : LOAD;
        else
            state_next = RUN;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= RUN;
            bus.instruction <= '0;
            bus.wr_count    <= '0;
            for (int i = 0; i < 2**AW; i++) begin
                imem[i] <= '0;
                dmem[i] <= '0;
            end
        end else begin
            state           <= state_next;
            bus.instruction <= (state == RUN) ? imem[bus.pc] : IW'(BUBBLE);
            if (bus.wr)
                dmem[bus.addr] <= bus.wdata;
            if (accept & bus.ld_sel)
                dmem[bus.ld_addr] <= bus.ld_data[DW-1:0];
            if (accept & ~bus.ld_sel)
                imem[bus.ld_addr] <= bus.ld_data;
            if (bus.wr & ~&bus.wr_count)
                bus.wr_count <= bus.wr_count + CW'(1);
        end
    end
endmodule
